// File: rtl/if_pkg.sv
// Shared types and constants for the multi-outstanding instruction fetch stage.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } ibuf_entry_t;

  localparam int unsigned IBUF_ENTRY_W = $bits(ibuf_entry_t);

  // Redirect sources, encoded in priority order.
  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_EX   = 2'd1,
    REDIR_ERTN = 2'd2,
    REDIR_BR   = 2'd3
  } redir_sel_e;

  function automatic redir_sel_e redir_select(input logic ex, input logic ertn, input logic br);
    if (ex)        return REDIR_EX;
    else if (ertn) return REDIR_ERTN;
    else if (br)   return REDIR_BR;
    else           return REDIR_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with flush; head entry read straight from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage_mo.sv
// Instruction fetch stage with up to MAX_OUTSTANDING in-order requests and an
// instruction buffer; stale responses after a redirect are dropped by count.
module if_stage_mo
  import if_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  output logic        fs_adef_ex,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IB_W  = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > IB_W) ? CNT_W : IB_W) + 1;

  logic [31:0]       pf_pc;
  logic [CNT_W-1:0]  discard_cnt;
  logic              adef_hold;

  logic [CNT_W-1:0]  inflight;
  logic              pcq_full;
  logic              pcq_empty;
  logic [31:0]       pcq_head;

  logic [IB_W-1:0]   ibuf_count;
  logic              ibuf_full;
  logic              ibuf_empty;
  logic [IBUF_ENTRY_W-1:0] ibuf_dout;
  ibuf_entry_t       ibuf_din;
  ibuf_entry_t       ibuf_head;

  redir_sel_e        redir_sel;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic [CNT_W-1:0]  live;
  logic              credit_ok;
  logic              aligned;
  logic              issue;
  logic              resp;
  logic              resp_keep;
  logic              adef_push;
  logic              ibuf_pop;

  always_comb begin
    redir_sel       = redir_select(wb_ex, ertn_flush, br_taken);
    redirect_target = pf_pc;
    case (redir_sel)
      REDIR_EX:   redirect_target = ex_entry;
      REDIR_ERTN: redirect_target = ertn_entry;
      REDIR_BR:   redirect_target = br_target;
      default:    redirect_target = pf_pc;
    endcase
  end

  assign redirect = (redir_sel != REDIR_NONE);

  // Every live (non-discarded) request must own a free buffer slot, since data_ok cannot stall.
  assign live      = inflight - discard_cnt;
  assign credit_ok = (SUM_W'(live) + SUM_W'(ibuf_count)) < SUM_W'(IBUF_DEPTH);
  assign aligned   = (pf_pc[1:0] == 2'b00);

  assign inst_sram_req   = ~reset & ~redirect & ~br_stall & ~adef_hold & aligned
                         & ~pcq_full & credit_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = pf_pc;
  assign inst_sram_wdata = 32'h0;

  assign issue     = inst_sram_req & inst_sram_addr_ok;
  assign resp      = inst_sram_data_ok & ~pcq_empty;
  assign resp_keep = resp & ~redirect & (discard_cnt == '0);
  assign adef_push = ~redirect & ~adef_hold & ~aligned & (inflight == '0) & ~ibuf_full;
  assign ibuf_pop  = fs_to_ds_valid & ds_allowin;

  always_comb begin
    ibuf_din.pc   = pcq_head;
    ibuf_din.inst = inst_sram_rdata;
    ibuf_din.adef = 1'b0;
    if (adef_push) begin
      ibuf_din.pc   = pf_pc;
      ibuf_din.inst = 32'h0;
      ibuf_din.adef = 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .pop   (resp),
    .flush (1'b0),
    .din   (pf_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (inflight),
    .dout  (pcq_head)
  );

  sync_fifo #(
    .WIDTH (IBUF_ENTRY_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (resp_keep | adef_push),
    .pop   (ibuf_pop),
    .flush (redirect),
    .din   (ibuf_din),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count),
    .dout  (ibuf_dout)
  );

  assign ibuf_head      = ibuf_entry_t'(ibuf_dout);
  assign fs_to_ds_valid = ~ibuf_empty;
  assign fs_inst        = ibuf_head.inst;
  assign fs_pc          = ibuf_head.pc;
  assign fs_adef_ex     = ibuf_head.adef;

  // Fetch PC, stale-response discard counter and address-error hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_pc       <= RESET_PC;
      discard_cnt <= '0;
      adef_hold   <= 1'b0;
    end else if (redirect) begin
      pf_pc       <= redirect_target;
      discard_cnt <= inflight - CNT_W'(resp);
      adef_hold   <= 1'b0;
    end else begin
      if (issue) pf_pc <= pf_pc + 32'd4;
      if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CNT_W'(1);
      if (adef_push) adef_hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_mo.sv
// Scoreboard bench for if_stage_mo: directed phases push expected deliveries,
// a monitor pops and compares every instruction handed to decode.
module tb_if_stage_mo;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_inst;
  logic [31:0] fs_pc;
  logic        fs_adef_ex;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage_mo dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_inst           (fs_inst),
    .fs_pc             (fs_pc),
    .fs_adef_ex        (fs_adef_ex),
    .br_stall          (br_stall),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .wb_ex             (wb_ex),
    .ex_entry          (ex_entry),
    .ertn_flush        (ertn_flush),
    .ertn_entry        (ertn_entry),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int fetch_base = 0;
  ibuf_entry_t exp_q[$];
  ibuf_entry_t mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // In-order memory: accepts when bus_ready, answers oldest request when resp_en.
  logic        bus_ready = 1'b1;
  logic        resp_en = 1'b1;
  logic [31:0] bus_q[$];
  logic        bus_has = 1'b0;
  logic [31:0] bus_head = '0;
  logic        acc_now = 1'b0;
  logic        resp_now = 1'b0;
  logic [31:0] acc_addr = '0;

  assign inst_sram_addr_ok = bus_ready;
  assign inst_sram_data_ok = resp_en & bus_has;
  assign inst_sram_rdata   = bus_has ? mem_word(bus_head) : 32'h0;

  always @(negedge clk) begin
    acc_now  = inst_sram_req & inst_sram_addr_ok;
    acc_addr = inst_sram_addr;
    resp_now = inst_sram_data_ok;
    if (acc_now && !reset) acc_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      bus_q.delete();
    end else begin
      if (resp_now) void'(bus_q.pop_front());
      if (acc_now) bus_q.push_back(acc_addr);
    end
    bus_has  = (bus_q.size() > 0);
    bus_head = bus_has ? bus_q[0] : 32'h0;
  end

  // Scoreboard monitor: every accepted delivery must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && fs_to_ds_valid && ds_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h, expected nothing", fs_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("deliver_pc", fs_pc, mon_e.pc);
        check("deliver_inst", fs_inst, mon_e.inst);
        check("deliver_adef", 32'(fs_adef_ex), 32'(mon_e.adef));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (int'(dut.inflight) > 2 || int'(dut.discard_cnt) > 2 || int'(dut.ibuf_count) > 4) begin
        errors++;
        $display("FAIL counter_bound: got inflight=%0d discard=%0d ibuf=%0d, expected <=2/2/4",
                 dut.inflight, dut.discard_cnt, dut.ibuf_count);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int n, input logic [31:0] pc0);
    ibuf_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = pc0 + 32'(4 * i);
      e.inst = mem_word(e.pc);
      e.adef = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Let fetch run until `total` requests have been accepted since fetch_base.
  task automatic run_fetch(input int total);
    br_stall = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (acc_cnt - fetch_base >= total) break;
      @(posedge clk);
      #2;
    end
    br_stall = 1'b1;
    check("fetch_count", 32'(acc_cnt - fetch_base), 32'(total));
  endtask

  task automatic drain();
    br_stall   = 1'b1;
    ds_allowin = 1'b1;
    resp_en    = 1'b1;
    wait_cycles(8);
  endtask

  initial begin
    ibuf_entry_t ae;
    reset = 1'b1; ds_allowin = 1'b1; br_stall = 1'b0;
    br_taken = 1'b0; br_target = '0; wb_ex = 1'b0; ex_entry = '0;
    ertn_flush = 1'b0; ertn_entry = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(fs_to_ds_valid), 0);
    check("rst_pc", fs_pc, 0);
    check("rst_inst", fs_inst, 0);
    check("rst_adef", 32'(fs_adef_ex), 0);
    check("rst_req", 32'(inst_sram_req), 0);
    check("rst_pf_pc", dut.pf_pc, RST_PC);

    // Streaming after reset release, one instruction per cycle
    @(posedge clk); #2;
    fetch_base = acc_cnt;
    push_exp(8, RST_PC);
    reset = 1'b0;
    @(negedge clk);
    check("first_req", 32'(inst_sram_req), 1);
    check("first_addr", inst_sram_addr, RST_PC);
    check("lat_cycle0_valid", 32'(fs_to_ds_valid), 0);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(fs_to_ds_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(fs_to_ds_valid), 1);
    check("lat_cycle2_pc", fs_pc, RST_PC);
    @(posedge clk); #2;
    run_fetch(8);

    // Decode stalled: credit limits fetch to exactly the buffer depth
    drain();
    ds_allowin = 1'b0;
    fetch_base = acc_cnt;
    br_stall = 1'b0;
    wait_cycles(10);
    check("credit_accepts", 32'(acc_cnt - fetch_base), 4);
    check("ibuf_full_count", 32'(dut.ibuf_count), 4);
    @(negedge clk);
    check("full_req_low", 32'(inst_sram_req), 0);
    check("full_head_pc", fs_pc, 32'h1c00_0020);
    @(posedge clk); #2;
    push_exp(8, 32'h1c00_0020);
    ds_allowin = 1'b1;
    run_fetch(8);

    // Branch with two requests outstanding: both responses discarded
    drain();
    resp_en = 1'b0;
    fetch_base = acc_cnt;
    run_fetch(2);
    br_target = 32'h1c00_0100; br_taken = 1'b1;
    @(negedge clk);
    check("br_req_low", 32'(inst_sram_req), 0);
    @(posedge clk); #2;
    br_taken = 1'b0; resp_en = 1'b1;
    check("discard_set", 32'(dut.discard_cnt), 2);
    wait_cycles(3);
    check("discard_done", 32'(dut.discard_cnt), 0);
    check("discard_no_valid", 32'(fs_to_ds_valid), 0);
    push_exp(4, 32'h1c00_0100);
    fetch_base = acc_cnt;
    run_fetch(4);

    // wb_ex and br_taken together with data_ok: exception wins, data dropped
    drain();
    resp_en = 1'b0;
    fetch_base = acc_cnt;
    run_fetch(1);
    resp_en = 1'b1; br_stall = 1'b0;
    wb_ex = 1'b1; ex_entry = 32'h1c00_1000;
    br_taken = 1'b1; br_target = 32'h1c00_0200;
    @(negedge clk);
    check("ex_req_low", 32'(inst_sram_req), 0);
    @(posedge clk); #2;
    wb_ex = 1'b0; br_taken = 1'b0;
    fetch_base = acc_cnt;
    push_exp(2, 32'h1c00_1000);
    check("ex_pf_pc", dut.pf_pc, 32'h1c00_1000);
    check("ex_discard", 32'(dut.discard_cnt), 0);
    check("ex_no_valid", 32'(fs_to_ds_valid), 0);
    @(negedge clk);
    check("ex_next_req", 32'(inst_sram_req), 1);
    check("ex_next_addr", inst_sram_addr, 32'h1c00_1000);
    @(posedge clk); #2;
    run_fetch(2);

    // ertn beats branch
    drain();
    ertn_flush = 1'b1; ertn_entry = 32'h1c00_2000;
    br_taken = 1'b1; br_target = 32'h1c00_3000;
    @(posedge clk); #2;
    ertn_flush = 1'b0; br_taken = 1'b0;
    push_exp(2, 32'h1c00_2000);
    fetch_base = acc_cnt;
    run_fetch(2);

    // Misaligned target: one adef entry, fetch held until exception redirect
    drain();
    br_taken = 1'b1; br_target = 32'h1c00_0102;
    @(posedge clk); #2;
    br_taken = 1'b0;
    ae.pc = 32'h1c00_0102; ae.inst = 32'h0; ae.adef = 1'b1;
    exp_q.push_back(ae);
    br_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("adef_no_req", 32'(inst_sram_req), 0);
      @(posedge clk); #2;
    end
    check("adef_hold_set", 32'(dut.adef_hold), 1);
    wb_ex = 1'b1; ex_entry = 32'h1c00_8000;
    @(posedge clk); #2;
    wb_ex = 1'b0;
    fetch_base = acc_cnt;
    push_exp(3, 32'h1c00_8000);
    @(negedge clk);
    check("adef_resume_addr", inst_sram_addr, 32'h1c00_8000);
    @(posedge clk); #2;
    run_fetch(3);

    // Asynchronous reset with buffered and in-flight work
    drain();
    ds_allowin = 1'b0;
    fetch_base = acc_cnt;
    run_fetch(3);
    wait_cycles(2);
    resp_en = 1'b0;
    fetch_base = acc_cnt;
    run_fetch(1);
    check("pre_rst_ibuf", 32'(dut.ibuf_count), 3);
    check("pre_rst_inflight", 32'(dut.inflight), 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(fs_to_ds_valid), 0);
    check("async_rst_pc", fs_pc, 0);
    check("async_rst_req", 32'(inst_sram_req), 0);
    wait_cycles(2);
    resp_en = 1'b1; ds_allowin = 1'b1;
    push_exp(3, RST_PC);
    fetch_base = acc_cnt;
    reset = 1'b0;
    run_fetch(3);

    drain();
    check("all_expected_delivered", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
